ca_run_controller: RTL
======================

# ca_run_controller

Run controller for the 8-cell elementary cellular automaton core. It accepts a run request with a rule, seed and generation budget, then loads the core. It steps the core one generation per clock and stops on a generation limit, a fixed point, an all-zero state, or an abort. On stop it freezes the core, reports the final state, generation count and stop reason, and pulses done. It sits between the host/register interface and the automaton core, which it drives through the core's rule, load-state and synchronous-reset pins.

## Interface
- GEN_W, 16, width of generation budget and counter

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  run request, sampled only in IDLE
- abort  in  1  terminate run, sampled only in RUN
- rule_in  in  8  Wolfram rule number, latched on accepted start
- seed_in  in  8  initial cell state, latched on accepted start
- max_gens  in  GEN_W  generation budget, latched on accepted start
- busy  out  1  high in LOAD and RUN
- done  out  1  one-cycle pulse in DONE
- final_state  out  8  state at stop; held until next accepted start
- gen_count  out  GEN_W  generation index of final_state
- stop_reason  out  2  0 LIMIT, 1 FIXED, 2 ZERO, 3 ABORT
- sim_rule  out  8  to core rule pin (registered rule)
- sim_state  out  8  to core input_state pin
- sim_load  out  1  to core rst pin; high means the core loads sim_state at the edge
- sim_result  in  8  core result

## Operation
- FSM states:
  - IDLE: on start=1, latch rule_in, seed_in and max_gens, then go to LOAD.
  - LOAD: always one cycle, then go to RUN.
  - RUN: loops until a stop condition, then goes to DONE.
  - DONE: one cycle, then go to IDLE.
- sim_load is combinational:
  - 1 in IDLE, LOAD and DONE, and while rst=1.
  - 1 in RUN only in the stop cycle.
  - 0 otherwise.
- sim_state is combinational:
  - 8'h00 while rst=1.
  - seed_reg in LOAD.
  - sim_result otherwise, so a load re-writes the current value and freezes the core.
- RUN bookkeeping:
  - gen counter is 0 in the first RUN cycle (sim_result = seed) and increments each non-stop RUN cycle.
  - prev register captures sim_result each RUN cycle.
- Stop evaluation runs every RUN cycle on the current sim_result. Priority is highest first:
  - ABORT: abort=1.
  - ZERO: sim_result == 0.
  - FIXED: gen > 0 and sim_result == prev.
  - LIMIT: gen == max_gens.
- In the stop cycle, register final_state=sim_result, gen_count=gen and stop_reason.
- Boundary conditions:
  - max_gens=0 with a nonzero seed stops in the first RUN cycle with LIMIT, gen_count=0.
  - A zero seed stops with ZERO at gen 0, regardless of max_gens.
  - gen never exceeds max_gens, so no counter overflow occurs. max_gens = 2^GEN_W−1 is legal.
  - start outside IDLE is ignored, including start in the DONE cycle.
  - abort outside RUN is ignored.
  - Period-2 or longer cycles are not detected; these runs end on LIMIT.

## Timing
- Reset values:
  - state=IDLE.
  - busy=0, done=0.
  - final_state=0, gen_count=0, stop_reason=0, sim_rule=0.
  - sim_load=1, sim_state=0.
- Reset mid-run returns to IDLE on the next edge and discards the run. No done pulse is produced. The core is forced to 0.
- Run timeline, with start sampled at edge k:
  - LOAD is cycle k+1.
  - First RUN cycle is k+2, with sim_result = seed at gen 0.
  - RUN cycle k+2+g shows generation g.
  - A stop at generation G gives done=1 in cycle k+3+G, with results valid from that cycle.
- busy falls in the same cycle done rises.
- Earliest next start is sampled in the cycle after done.
- Core state after stop equals final_state and stays there until the next LOAD.

## Test plan
- Rule 204 (identity), seed 0xA5, max 10 -> FIXED, gen_count 1, final 0xA5; done 4 cycles after start.
- Rule 0, seed 0x5A, max 10 -> ZERO, gen_count 1, final 0x00. Seed 0x00 with any rule -> ZERO, gen_count 0.
- Rule 51 (NOT center), seed 0x0F, max 4 -> states alternate 0x0F/0xF0; result is LIMIT, gen_count 4, final 0x0F. max_gens=0 -> LIMIT, gen_count 0, final 0x0F.
- Rule 51, seed 0x0F, max 100, abort in the gen-3 RUN cycle -> ABORT, gen_count 3, final 0xF0. Core result stays 0xF0 for 5 further cycles.
- Rule 170, seed 0x81, max 3 -> final 0x0C, gen_count 3. Also pulse start during RUN -> ignored, exactly one done pulse.
- rst asserted at gen 2 of a rule-51 run -> next cycle busy=0, done=0, all outputs 0, core result 0x00. A fresh start then runs normally.

Source files
------------

// File: rtl/ca_run_if.sv
// Bundle of host-side run controls and core-side drive/result signals.
// Latency: none, wires only.
// Backpressure: none; start/abort are level-sampled by the controller.
interface ca_run_if #(
  parameter int GEN_W = 16
);
  logic             start;
  logic             abort;
  logic [7:0]       rule_in;
  logic [7:0]       seed_in;
  logic [GEN_W-1:0] max_gens;
  logic             busy;
  logic             done;
  logic [7:0]       final_state;
  logic [GEN_W-1:0] gen_count;
  logic [1:0]       stop_reason;
  logic [7:0]       sim_rule;
  logic [7:0]       sim_state;
  logic             sim_load;
  logic [7:0]       sim_result;

  // Host plus core side: drives requests and the core result, observes the controller.
  modport master (
    output start, abort, rule_in, seed_in, max_gens, sim_result,
    input  busy, done, final_state, gen_count, stop_reason,
    input  sim_rule, sim_state, sim_load
  );

  // Controller side.
  modport slave (
    input  start, abort, rule_in, seed_in, max_gens, sim_result,
    output busy, done, final_state, gen_count, stop_reason,
    output sim_rule, sim_state, sim_load
  );
endinterface

// File: rtl/ca_run_controller.sv
// Run controller: loads the 8-cell CA core, steps it, stops on limit/fixed/zero/abort.
// Latency: done pulses G+3 cycles after start is sampled, G = stopping generation.
// Backpressure: start ignored unless idle; abort ignored unless running.
module ca_run_controller #(
  parameter int GEN_W = 16
) (
  input logic    clk,
  input logic    rst,
  ca_run_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] STOP_LIMIT = 2'd0;
  localparam logic [1:0] STOP_FIXED = 2'd1;
  localparam logic [1:0] STOP_ZERO  = 2'd2;
  localparam logic [1:0] STOP_ABORT = 2'd3;

  state_t           state;
  logic [7:0]       rule_reg;
  logic [7:0]       seed_reg;
  logic [7:0]       prev_reg;
  logic [7:0]       final_reg;
  logic [GEN_W-1:0] max_reg;
  logic [GEN_W-1:0] gen;
  logic [GEN_W-1:0] gen_count_reg;
  logic [1:0]       reason_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             stop_hit;
  logic [1:0]       stop_code;

  // Stop detection on the current core result, highest priority first.
  // gen never passes max_reg, so the equality test is a safe limit check
  // even at the all-ones budget.
  always_comb begin
    stop_hit  = 1'b0;
    stop_code = STOP_LIMIT;
    if (state == RUN) begin
      if (bus.abort) begin
        stop_hit  = 1'b1;
        stop_code = STOP_ABORT;
      end else if (bus.sim_result == 8'h00) begin
        stop_hit  = 1'b1;
        stop_code = STOP_ZERO;
      end else if ((gen != '0) && (bus.sim_result == prev_reg)) begin
        stop_hit  = 1'b1;
        stop_code = STOP_FIXED;
      end else if (gen == max_reg) begin
        stop_hit  = 1'b1;
        stop_code = STOP_LIMIT;
      end
    end
  end

  // Core drive: loading the current result back into the core freezes it, so
  // the core only advances in non-stop RUN cycles. Reset forces it to zero.
  assign bus.sim_load  = rst || (state != RUN) || stop_hit;
  assign bus.sim_state = rst            ? 8'h00 :
                         (state == LOAD) ? seed_reg :
                                           bus.sim_result;

  assign bus.sim_rule    = rule_reg;
  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.final_state = final_reg;
  assign bus.gen_count   = gen_count_reg;
  assign bus.stop_reason = reason_reg;

  // Run sequencing with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rule_reg      <= 8'h00;
      seed_reg      <= 8'h00;
      prev_reg      <= 8'h00;
      final_reg     <= 8'h00;
      max_reg       <= '0;
      gen           <= '0;
      gen_count_reg <= '0;
      reason_reg    <= STOP_LIMIT;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            rule_reg <= bus.rule_in;
            seed_reg <= bus.seed_in;
            max_reg  <= bus.max_gens;
            busy_reg <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          gen   <= '0;
          state <= RUN;
        end
        RUN: begin
          prev_reg <= bus.sim_result;
          if (stop_hit) begin
            final_reg     <= bus.sim_result;
            gen_count_reg <= gen;
            reason_reg    <= stop_code;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
            state         <= DONE;
          end else begin
            gen <= gen + GEN_W'(1);
          end
        end
        DONE: begin
          done_reg <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
